// File: rtl/alu_sequencer.sv
// Multi-cycle issue controller between the control unit and a combinational ALU.
// Latches one request, holds ALU inputs for the op's settle time, then returns R/S/cause.
module alu_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int CTRL_WIDTH = 4,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [CTRL_WIDTH-1:0] req_ctrl,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [CTRL_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_r,
  input  logic [DATA_WIDTH-1:0] alu_s,
  input  logic                  alu_exc,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_r,
  output logic [DATA_WIDTH-1:0] resp_s,
  output logic [1:0]            resp_cause,
  output logic [CNT_WIDTH-1:0]  op_count,
  output logic [CNT_WIDTH-1:0]  exc_count
);

  localparam logic [CTRL_WIDTH-1:0] OP_NOP = CTRL_WIDTH'(4'b0000);
  localparam logic [CTRL_WIDTH-1:0] OP_MUL = CTRL_WIDTH'(4'b0001);
  localparam logic [CTRL_WIDTH-1:0] OP_DIV = CTRL_WIDTH'(4'b0010);
  localparam logic [CTRL_WIDTH-1:0] OP_ROR = CTRL_WIDTH'(4'b1000);
  localparam logic [CTRL_WIDTH-1:0] OP_ROL = CTRL_WIDTH'(4'b1001);
  localparam logic [CTRL_WIDTH-1:0] OP_SLL = CTRL_WIDTH'(4'b1010);
  localparam logic [CTRL_WIDTH-1:0] OP_SLR = CTRL_WIDTH'(4'b1011);
  localparam logic [CTRL_WIDTH-1:0] OP_OR  = CTRL_WIDTH'(4'b1100);
  localparam logic [CTRL_WIDTH-1:0] OP_AND = CTRL_WIDTH'(4'b1101);
  localparam logic [CTRL_WIDTH-1:0] OP_SUB = CTRL_WIDTH'(4'b1110);
  localparam logic [CTRL_WIDTH-1:0] OP_ADD = CTRL_WIDTH'(4'b1111);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int WAIT_W     = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   a_reg, a_next;
  logic [DATA_WIDTH-1:0]   b_reg, b_next;
  logic [CTRL_WIDTH-1:0]   ctrl_reg, ctrl_next;
  logic [WAIT_W-1:0]       wait_reg, wait_next;
  logic [DATA_WIDTH-1:0]   r_reg, r_next;
  logic [DATA_WIDTH-1:0]   s_reg, s_next;
  logic [1:0]              cause_reg, cause_next;
  logic [CNT_WIDTH-1:0]    op_cnt_reg, op_cnt_next;
  logic [CNT_WIDTH-1:0]    exc_cnt_reg, exc_cnt_next;

  function automatic logic is_legal(input logic [CTRL_WIDTH-1:0] c);
    case (c)
      OP_NOP, OP_MUL, OP_DIV, OP_ROR, OP_ROL, OP_SLL,
      OP_SLR, OP_OR, OP_AND, OP_SUB, OP_ADD: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      ctrl_reg    <= OP_NOP;
      wait_reg    <= '0;
      r_reg       <= '0;
      s_reg       <= '0;
      cause_reg   <= 2'b00;
      op_cnt_reg  <= '0;
      exc_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      ctrl_reg    <= ctrl_next;
      wait_reg    <= wait_next;
      r_reg       <= r_next;
      s_reg       <= s_next;
      cause_reg   <= cause_next;
      op_cnt_reg  <= op_cnt_next;
      exc_cnt_reg <= exc_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    ctrl_next    = ctrl_reg;
    wait_next    = wait_reg;
    r_next       = r_reg;
    s_next       = s_reg;
    cause_next   = cause_reg;
    op_cnt_next  = op_cnt_reg;
    exc_cnt_next = exc_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          a_next    = req_a;
          b_next    = req_b;
          ctrl_next = req_ctrl;
          // Faults are answered directly from IDLE; the ALU never sees them.
          if (!is_legal(req_ctrl)) begin
            r_next     = '0;
            s_next     = '0;
            cause_next = 2'b11;
            state_next = DONE;
          end else if (req_ctrl == OP_DIV && req_b == '0) begin
            r_next     = '0;
            s_next     = '0;
            cause_next = 2'b10;
            state_next = DONE;
          end else begin
            if (req_ctrl == OP_MUL)      wait_next = WAIT_W'(MUL_CYCLES - 1);
            else if (req_ctrl == OP_DIV) wait_next = WAIT_W'(DIV_CYCLES - 1);
            else                         wait_next = '0;
            state_next = EXEC;
          end
        end
      end
      EXEC: begin
        if (wait_reg == '0) begin
          r_next     = alu_r;
          s_next     = (ctrl_reg == OP_MUL || ctrl_reg == OP_DIV) ? alu_s : '0;
          cause_next = alu_exc ? 2'b01 : 2'b00;
          state_next = DONE;
        end else begin
          wait_next = wait_reg - 1'b1;
        end
      end
      DONE: begin
        if (resp_ready) begin
          op_cnt_next = op_cnt_reg + 1'b1;
          if (cause_reg != 2'b00) exc_cnt_next = exc_cnt_reg + 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == DONE);
  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign alu_ctrl   = (state_reg == EXEC) ? ctrl_reg : OP_NOP;
  assign resp_r     = r_reg;
  assign resp_s     = s_reg;
  assign resp_cause = cause_reg;
  assign op_count   = op_cnt_reg;
  assign exc_count  = exc_cnt_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer with a settle-time-aware ALU stand-in.
module tb_alu_sequencer;
  localparam int DW   = 16;
  localparam int CW   = 4;
  localparam int MULC = 2;
  localparam int DIVC = 4;
  localparam int CNTW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_a, req_b;
  logic [CW-1:0] req_ctrl;
  logic [DW-1:0] alu_a, alu_b;
  logic [CW-1:0] alu_ctrl;
  logic [DW-1:0] alu_r, alu_s;
  logic          alu_exc;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_r, resp_s;
  logic [1:0]    resp_cause;
  logic [CNTW-1:0] op_count, exc_count;

  alu_sequencer #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .MUL_CYCLES(MULC),
                  .DIV_CYCLES(DIVC), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_r(alu_r), .alu_s(alu_s), .alu_exc(alu_exc),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_r(resp_r), .resp_s(resp_s), .resp_cause(resp_cause),
    .op_count(op_count), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ALU stand-in: returns {exc, s, r}
  function automatic logic [2*DW:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [3:0] c);
    logic [DW-1:0]   r;
    logic [DW-1:0]   s;
    logic            e;
    logic [2*DW-1:0] p;
    int              sh;
    r = '0; s = a ^ b; e = 1'b0; sh = int'(b[3:0]);
    case (c)
      4'hF: begin r = a + b; e = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
      4'hE: begin r = a - b; e = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
      4'hD: r = a & b;
      4'hC: r = a | b;
      4'h1: begin p = {16'b0, a} * {16'b0, b}; r = p[DW-1:0]; s = p[2*DW-1:DW]; end
      4'h2: begin
        if (b != '0) begin r = a / b; s = a % b; end
        else begin r = '1; s = a; e = 1'b1; end
      end
      4'hA: r = a << sh;
      4'hB: r = a >> sh;
      4'h9: r = (a << sh) | (a >> (DW - sh));
      4'h8: r = (a >> sh) | (a << (DW - sh));
      4'h0: r = '0;
      default: begin r = 16'hBAD0; e = 1'b1; end
    endcase
    return {e, s, r};
  endfunction

  function automatic int need_cycles(input logic [3:0] c);
    if (c == 4'h1) return MULC;
    if (c == 4'h2) return DIVC;
    return 1;
  endfunction

  // Inputs must stay put long enough before the ALU answers truthfully.
  int stable = 0;
  logic [2*DW+CW-1:0] prev_in = '0;
  always @(negedge clk) begin
    if ({alu_a, alu_b, alu_ctrl} == prev_in) stable <= stable + 1;
    else stable <= 0;
    prev_in <= {alu_a, alu_b, alu_ctrl};
  end

  always_comb begin
    {alu_exc, alu_s, alu_r} = alu_fn(alu_a, alu_b, alu_ctrl);
    if (stable < need_cycles(alu_ctrl) - 1) begin
      alu_r = 16'hDEAD; alu_s = 16'hBEEF; alu_exc = 1'b1;
    end
  end

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] s;
    logic [1:0]    cause;
    int            lat;
    int            acc;
  } exp_t;

  exp_t q[$];

  function automatic exp_t ref_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     input logic [3:0] c);
    exp_t e;
    logic [2*DW:0] res;
    e.acc = 0;
    if (!(c inside {4'hF, 4'hE, 4'hD, 4'hC, 4'h1, 4'h2, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0})) begin
      e.r = '0; e.s = '0; e.cause = 2'b11; e.lat = 1;
    end else if (c == 4'h2 && b == '0) begin
      e.r = '0; e.s = '0; e.cause = 2'b10; e.lat = 1;
    end else begin
      res     = alu_fn(a, b, c);
      e.r     = res[DW-1:0];
      e.s     = (c == 4'h1 || c == 4'h2) ? res[2*DW-1:DW] : '0;
      e.cause = res[2*DW] ? 2'b01 : 2'b00;
      e.lat   = (c == 4'h1) ? 1 + MULC : (c == 4'h2) ? 1 + DIVC : 2;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard on each new response and owns resp_ready.
  logic            mon_en = 1'b0;
  logic            rand_rr = 1'b0;
  int              stall_req = 0;
  int              stall_left = 0;
  logic            was_valid = 1'b0;
  logic            cnt_pending = 1'b0;
  logic [CNTW-1:0] m_ops = '0;
  logic [CNTW-1:0] m_exc = '0;
  exp_t            cur;
  logic [2*DW+1:0] held;

  always @(negedge clk) begin
    if (mon_en) begin
      if (cnt_pending) begin
        check("op_count", 32'(op_count), 32'(m_ops));
        check("exc_count", 32'(exc_count), 32'(m_exc));
        check("idle_after_handshake", 32'(req_ready), 32'd1);
        cnt_pending = 1'b0;
      end
      if (resp_valid) begin
        if (!was_valid) begin
          if (q.size() == 0) begin
            check("unexpected_response", 32'(resp_valid), 32'd0);
          end else begin
            cur = q.pop_front();
            check("resp_r", 32'(resp_r), 32'(cur.r));
            check("resp_s", 32'(resp_s), 32'(cur.s));
            check("resp_cause", 32'(resp_cause), 32'(cur.cause));
            check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
            $display("resp: r=%h s=%h cause=%b latency=%0d", resp_r, resp_s, resp_cause,
                     cyc - cur.acc);
          end
          held = {resp_r, resp_s, resp_cause};
          stall_left = stall_req;
          stall_req = 0;
        end else begin
          check("resp_stable", 32'({resp_r, resp_s, resp_cause} != held), 32'd0);
        end
        check("busy_ready_low", 32'(req_ready), 32'd0);
        if (stall_left > 0) begin
          resp_ready = 1'b0;
          stall_left--;
        end else begin
          resp_ready = rand_rr ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (resp_ready) begin
          m_ops = m_ops + 1'b1;
          if (cur.cause != 2'b00) m_exc = m_exc + 1'b1;
          cnt_pending = 1'b1;
        end
      end else begin
        resp_ready = 1'($urandom_range(0, 1));
      end
      was_valid = resp_valid;
    end
  end

  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] c);
    exp_t e;
    int   tries = 0;
    @(negedge clk);
    while (!req_ready && tries < 60) begin
      req_valid = 1'($urandom_range(0, 1));
      req_a     = DW'($urandom);
      req_b     = DW'($urandom);
      req_ctrl  = CW'($urandom);
      tries++;
      @(negedge clk);
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    req_valid = 1'b1; req_a = a; req_b = b; req_ctrl = c;
    e = ref_model(a, b, c);
    e.acc = cyc;
    q.push_back(e);
    $display("req: a=%h b=%h ctrl=%h expect r=%h s=%h cause=%b", a, b, c, e.r, e.s, e.cause);
    @(negedge clk);
    req_valid = 1'b0;
    req_a = DW'($urandom); req_b = DW'($urandom); req_ctrl = CW'($urandom);
    if (e.cause[1]) begin
      check("no_alu_issue", 32'(alu_ctrl), 32'd0);
    end else begin
      check("issue_ctrl", 32'(alu_ctrl), 32'(c));
      check("issue_ops", {alu_a, alu_b}, {a, b});
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || resp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  logic [3:0] legal_codes [11] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'h1, 4'h2,
                                   4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  initial begin
    logic [3:0]    c;
    logic [DW-1:0] a, b;
    reset_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_ctrl = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_alu", {alu_a, alu_b}, 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst_resp", {resp_r, resp_s}, 32'd0);
    check("rst_cause", 32'(resp_cause), 32'd0);
    check("rst_counts", {op_count, exc_count}, 32'd0);
    reset_n = 1'b1;

    // Reset in the middle of a MUL must drop it silently.
    @(negedge clk);
    req_valid = 1'b1; req_a = 16'h1234; req_b = 16'h0100; req_ctrl = 4'h1;
    @(negedge clk);
    req_valid = 1'b0;
    check("mul_in_exec", 32'(alu_ctrl), 32'h1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("midrst_counts", {op_count, exc_count}, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_resp", 32'(resp_valid), 32'd0);

    mon_en = 1'b1;
    rand_rr = 1'b0;
    issue(16'h0003, 16'h0004, 4'hF);
    issue(16'h1234, 16'h0100, 4'h1);
    issue(16'h0007, 16'h0000, 4'h2);
    issue(16'h0007, 16'h0002, 4'h2);
    issue(16'h7FFF, 16'h0001, 4'hF);
    issue(16'h00AA, 16'h0055, 4'h3);
    issue(16'h5555, 16'h1234, 4'h0);
    drain();

    // Backpressure: hold the response for 5 cycles while another request waits.
    stall_req = 5;
    issue(16'h0100, 16'h0023, 4'hF);
    issue(16'h0050, 16'h0010, 4'hE);
    drain();

    rand_rr = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 2) c = CW'($urandom);
      else c = legal_codes[$urandom_range(0, 10)];
      a = DW'($urandom);
      b = DW'($urandom);
      if (c == 4'h2 && $urandom_range(0, 3) == 0) b = '0;
      issue(a, b, c);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle issue controller between the CPU control unit and the combinational ALU.
- Accepts one operation through a valid/ready request handshake and drives the ALU operand and function-code inputs from registered copies.
- Holds MUL/DIV operands stable for a configurable number of settle cycles, then captures R/S/exception and returns them through a valid/ready response handshake.
- Pre-screens divide-by-zero and illegal function codes without issuing them; keeps completion and exception counters.

Parameters:
- DATA_WIDTH, 16, operand/result width (matches ALU register width).
- CTRL_WIDTH, 4, function-code width.
- MUL_CYCLES, 2, cycles ALU inputs are held for MUL before capture (>=1).
- DIV_CYCLES, 4, cycles ALU inputs are held for DIV before capture (>=1).
- CNT_WIDTH, 16, width of statistics counters.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  DATA_WIDTH  operand A.
- req_b  in  DATA_WIDTH  operand B.
- req_ctrl  in  CTRL_WIDTH  function code.
- alu_a  out  DATA_WIDTH  to ALU A.
- alu_b  out  DATA_WIDTH  to ALU B.
- alu_ctrl  out  CTRL_WIDTH  to ALU ALU_Ctrl.
- alu_r  in  DATA_WIDTH  from ALU R.
- alu_s  in  DATA_WIDTH  from ALU S.
- alu_exc  in  1  from ALU_Exception.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_r  out  DATA_WIDTH  primary result.
- resp_s  out  DATA_WIDTH  secondary result (MUL upper half / DIV remainder), else 0.
- resp_cause  out  2  00 ok, 01 ALU exception, 10 divide by zero, 11 illegal code.
- op_count  out  CNT_WIDTH  completed responses.
- exc_count  out  CNT_WIDTH  completed responses with resp_cause != 00.

Behaviour:
- Clock/reset: one clock, clk. reset_n is synchronous and active-low. Reset drops any in-flight op.
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_r, resp_s, resp_cause=0; alu_a, alu_b=0; alu_ctrl=0000 (NOP); both counters 0.
- Legal codes: 1111 ADD, 1110 SUB, 1101 AND, 1100 OR, 0001 MUL, 0010 DIV, 1010 SLL, 1011 SLR, 1001 ROL, 1000 ROR, 0000 NOP. All others are illegal.
- States: IDLE, EXEC, DONE.
- IDLE:
  - req_ready=1 (combinational from state); alu_ctrl=NOP.
  - On req_valid, latch a/b/ctrl.
  - Illegal code -> DONE with cause 11, resp_r=resp_s=0, ALU not issued.
  - DIV with req_b==0 -> DONE with cause 10, resp_r=resp_s=0, ALU not issued.
  - Otherwise -> EXEC, load wait counter: MUL_CYCLES-1 for MUL, DIV_CYCLES-1 for DIV, 0 for all other codes.
- EXEC:
  - req_ready=0; alu_a/alu_b/alu_ctrl driven from latched regs and held constant.
  - Counter decrements each cycle. On the cycle the counter is 0, capture alu_r into resp_r.
  - resp_s takes alu_s for MUL/DIV, else 0.
  - cause = 01 if alu_exc else 00; alu_exc is sampled only on the capture cycle.
  - Then -> DONE; alu_ctrl returns to NOP.
- DONE:
  - resp_valid=1; resp_* stable until the handshake.
  - On resp_ready: op_count+1; exc_count+1 if cause != 00; -> IDLE.
  - No new request is accepted in the same cycle (req_ready=0 in DONE).
- Latency (request accepted at cycle t):
  - Short ops: resp_valid first high at t+2.
  - MUL: t+1+MUL_CYCLES. DIV: t+1+DIV_CYCLES.
  - Pre-screened faults: t+1.
- NOP: issued normally; result 0, cause 00.
- Counters wrap modulo 2^CNT_WIDTH.
- Request inputs are ignored outside IDLE. Changing req_* while req_ready=0 has no effect.
- Reset asserted in EXEC or DONE: next cycle all reset values apply, no response is emitted, counters are not incremented.

Test Plan:
- Reset: reset_n=0 for 2 cycles mid-MUL (EXEC) -> resp_valid=0, req_ready=1, alu_ctrl=0000, counters 0.
- ADD 0x0003+0x0004 accepted at t, resp_ready=1 -> resp_valid at t+2, resp_r=0x0007, resp_s=0, cause 00, op_count=1.
- MUL 0x1234*0x0100, MUL_CYCLES=2 -> alu_ctrl=0001 held for 2 cycles, resp_valid at t+3, resp_r=0x3400, resp_s=0x0012.
- DIV 0x0007/0x0000 -> no ALU issue (alu_ctrl stays 0000), resp_valid at t+1, cause 10, exc_count=1; then DIV 0x0007/0x0002 -> resp_r=0x0003, resp_s=0x0001 at t+5.
- ADD 0x7FFF+0x0001 -> cause 01, resp_r=0x8000. Then code 0x3 -> cause 11. exc_count increments for each.
- Backpressure: resp_ready=0 for 5 cycles in DONE -> resp_* stable, req_ready=0, new req_valid ignored; on release, IDLE the next cycle and the next request is accepted.
